controller_tx: RTL and testbench



---
 rtl/controller_tx_if.sv | 24 ++
 rtl/controller_tx.sv | 144 ++++++++++++++
 tb/tb_controller_tx.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/controller_tx_if.sv
// Interface bundling the controller_tx handshake: host start, UART done, PISO/UART strobes and status.
interface controller_tx_if;
    logic       start;
    logic       tx_done;
    logic       EnEnc;
    logic       Ld;
    logic       Rd;
    logic       EnTx;
    logic       PISO_reset;
    logic       busy;
    logic       block_done;
    logic       err;
    logic [7:0] byte_cnt;

    modport master (
        input  start, tx_done,
        output EnEnc, Ld, Rd, EnTx, PISO_reset, busy, block_done, err, byte_cnt
    );

    modport slave (
        output start, tx_done,
        input  EnEnc, Ld, Rd, EnTx, PISO_reset, busy, block_done, err, byte_cnt
    );
endinterface

// File: rtl/controller_tx.sv
// Transmit sequencer for the AES-over-UART link: encrypt, load PISO, send NUM_BYTES bytes over UART.
// Optional per-byte watchdog enabled by defining TX_TIMEOUT_EN.
module controller_tx #(
    parameter int NUM_BYTES      = 16,
    parameter int ENC_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input logic           clk,
    input logic           reset,
    controller_tx_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ENC, S_LOAD, S_SEND, S_WAIT_DONE, S_WAIT_UNDONE, S_NEXT, S_FINISH
    } state_t;

    localparam logic [7:0] LAST_BYTE = 8'(NUM_BYTES - 1);
    localparam logic [7:0] LAST_ENC  = 8'(ENC_CYCLES - 1);

    generate
        if (NUM_BYTES < 1 || NUM_BYTES > 255 || ENC_CYCLES < 1 || ENC_CYCLES > 255 ||
            TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("controller_tx: parameter out of range");
        end
    endgenerate

    state_t     state;
    state_t     state_nx;
    logic [7:0] byte_cnt;
    logic [7:0] enc_cnt;
    logic       timeout;
    logic       err;

`ifdef TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_cnt;
    logic            waiting;

    assign waiting = (state == S_WAIT_DONE) || (state == S_WAIT_UNDONE);
    assign timeout = waiting && (wd_cnt == WD_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state == S_SEND) begin
            wd_cnt <= '0;
        end else if (waiting) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Sticky across FINISH/IDLE; only an accepted start or reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (state == S_IDLE && bus.start) begin
            err <= 1'b0;
        end else if (timeout) begin
            err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt <= '0;
            enc_cnt  <= '0;
        end else begin
            enc_cnt <= (state == S_ENC && enc_cnt != LAST_ENC) ? enc_cnt + 8'd1 : '0;
            case (state)
                S_IDLE:   if (bus.start) byte_cnt <= '0;
                S_NEXT:   if (byte_cnt != LAST_BYTE) byte_cnt <= byte_cnt + 8'd1;
                S_FINISH: byte_cnt <= '0;
                default:  ;
            endcase
        end
    end

    always_comb begin
        state_nx       = state;
        bus.EnEnc      = 1'b0;
        bus.Ld         = 1'b0;
        bus.Rd         = 1'b0;
        bus.EnTx       = 1'b0;
        bus.PISO_reset = 1'b0;
        bus.block_done = 1'b0;
        bus.busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (bus.start) state_nx = S_ENC;
            end
            S_ENC: begin
                bus.EnEnc = 1'b1;
                if (enc_cnt == LAST_ENC) state_nx = S_LOAD;
            end
            S_LOAD: begin
                bus.EnEnc = 1'b1;
                bus.Ld    = 1'b1;
                state_nx  = S_SEND;
            end
            S_SEND: begin
                bus.EnEnc = 1'b1;
                bus.EnTx  = 1'b1;
                state_nx  = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                bus.EnEnc = 1'b1;
                if (timeout)          state_nx = S_FINISH;
                else if (bus.tx_done) state_nx = S_WAIT_UNDONE;
            end
            // Require tx_done to drop so a held-high done cannot advance two bytes.
            S_WAIT_UNDONE: begin
                bus.EnEnc = 1'b1;
                if (timeout)           state_nx = S_FINISH;
                else if (!bus.tx_done) state_nx = S_NEXT;
            end
            S_NEXT: begin
                bus.Rd   = 1'b1;
                state_nx = (byte_cnt == LAST_BYTE) ? S_FINISH : S_SEND;
            end
            S_FINISH: begin
                bus.block_done = 1'b1;
                bus.PISO_reset = 1'b1;
                state_nx       = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign bus.byte_cnt = byte_cnt;
    assign bus.err      = err;
endmodule

// File: tb/tb_controller_tx.sv
// Self-checking bench for controller_tx: cycle table on a NUM_BYTES=1/ENC_CYCLES=3 instance,
// directed block sequences with a UART done model on a default 16-byte instance.
module tb_controller_tx;
    logic clk;
    logic rst16;
    logic rst1;

    controller_tx_if bus16 ();
    controller_tx_if bus1 ();

    controller_tx dut16 (
        .clk   (clk),
        .reset (rst16),
        .bus   (bus16.master)
    );

    controller_tx #(
        .NUM_BYTES      (1),
        .ENC_CYCLES     (3),
        .TIMEOUT_CYCLES (50)
    ) dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (bus1.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vec_n  = 0;
    int miss_n = 0;

    task automatic tally(input string name, input bit ok, input int got, input int exp);
        vec_n++;
        if (!ok) begin
            miss_n++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        tally(name, got == exp, got, exp);
    endtask

    function automatic logic [15:0] obs1();
        return {bus1.EnEnc, bus1.Ld, bus1.Rd, bus1.EnTx, bus1.PISO_reset,
                bus1.busy, bus1.block_done, bus1.err, bus1.byte_cnt};
    endfunction

    function automatic logic [15:0] obs16();
        return {bus16.EnEnc, bus16.Ld, bus16.Rd, bus16.EnTx, bus16.PISO_reset,
                bus16.busy, bus16.block_done, bus16.err, bus16.byte_cnt};
    endfunction

    // UART done model for the 16-byte instance: tx_done rises uart_lat negedges after EnTx, held uart_hold.
    int uart_lat  = 100;
    int uart_hold = 2;
    bit uart_rst  = 1'b1;
    int cd = 0;
    int hc = 0;

    always @(negedge clk) begin
        if (uart_rst) begin
            cd = 0;
            hc = 0;
            bus16.tx_done = 1'b0;
        end else begin
            if (cd != 0) begin
                cd--;
                if (cd == 0) begin
                    bus16.tx_done = 1'b1;
                    hc = uart_hold;
                end
            end else if (hc != 0) begin
                hc--;
                if (hc == 0) bus16.tx_done = 1'b0;
            end
            if (bus16.EnTx) cd = uart_lat;
        end
    end

    // Strobe counters and byte-order check on the 16-byte instance.
    int ld_n, tx_n, rd_n, bd_n, exp_idx;

    always @(negedge clk) begin
        if (!rst16) begin
            if (bus16.Ld) ld_n++;
            if (bus16.Rd) rd_n++;
            if (bus16.block_done) bd_n++;
            if (bus16.EnTx) begin
                check("byte_order", int'(bus16.byte_cnt), exp_idx);
                exp_idx++;
                tx_n++;
            end
        end
    end

    task automatic clear_counts();
        ld_n = 0; tx_n = 0; rd_n = 0; bd_n = 0; exp_idx = 0;
    endtask

    task automatic wait_bd16(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (bus16.block_done) begin
                ok = 1'b1;
                break;
            end
        end
        tally({name, "_timeout"}, ok, 0, 1);
    endtask

    task automatic run_block16(input int lat, input int hold, input string name);
        uart_lat  = lat;
        uart_hold = hold;
        clear_counts();
        bus16.start = 1'b1;
        @(negedge clk);
        bus16.start = 1'b0;
        wait_bd16(name);
        @(negedge clk);
        check({name, "_busy_after"}, int'(bus16.busy), 0);
        check({name, "_ld"}, ld_n, 1);
        check({name, "_entx"}, tx_n, 16);
        check({name, "_rd"}, rd_n, 16);
        check({name, "_block_done"}, bd_n, 1);
    endtask

    typedef struct {
        logic       rst;
        logic       st;
        logic       txd;
        logic [7:0] flags;  // {EnEnc,Ld,Rd,EnTx,PISO_reset,busy,block_done,err}
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'b0000_0000, 8'd0};  // reset -> IDLE
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'b1000_0100, 8'd0};  // ENC 1
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'b1000_0100, 8'd0};  // ENC 2
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'b1000_0100, 8'd0};  // ENC 3
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'b1100_0100, 8'd0};  // LOAD
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'b1001_0100, 8'd0};  // SEND
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'b1000_0100, 8'd0};  // WAIT_DONE, start ignored
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'b1000_0100, 8'd0};  // WAIT_DONE
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'b1000_0100, 8'd0};  // WAIT_UNDONE
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'b1000_0100, 8'd0};  // WAIT_UNDONE, held done
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'b0010_0100, 8'd0};  // NEXT
        vecs[11] = '{1'b0, 1'b1, 1'b0, 8'b0000_1110, 8'd0};  // FINISH
        vecs[12] = '{1'b0, 1'b1, 1'b0, 8'b0000_0000, 8'd0};  // single IDLE cycle
        vecs[13] = '{1'b0, 1'b1, 1'b0, 8'b1000_0100, 8'd0};  // re-enter ENC
        vecs[14] = '{1'b1, 1'b1, 1'b0, 8'b0000_0000, 8'd0};  // reset wins over start
        vecs[15] = '{1'b0, 1'b0, 1'b0, 8'b0000_0000, 8'd0};  // IDLE

        rst16 = 1'b1;
        rst1  = 1'b1;
        bus16.start = 1'b0;
        bus1.start  = 1'b0;
        bus1.tx_done = 1'b0;
        clear_counts();
        repeat (3) @(negedge clk);

        // Cycle-accurate table on the NUM_BYTES=1, ENC_CYCLES=3 instance.
        for (int i = 0; i < 16; i++) begin
            rst1         = vecs[i].rst;
            bus1.start   = vecs[i].st;
            bus1.tx_done = vecs[i].txd;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), int'(obs1()), int'({vecs[i].flags, vecs[i].cnt}));
            @(negedge clk);
        end

        // 16-byte instance: reset state, then full blocks.
        @(posedge clk);
        #1;
        check("reset16", int'(obs16()), 0);
        @(negedge clk);
        rst16 = 1'b0;
        uart_rst = 1'b0;
        run_block16(100, 2, "blk_lat100");
        run_block16(5, 20, "blk_hold20");

        // Reset in WAIT_DONE of byte 5, then a fresh block.
        clear_counts();
        uart_lat = 100;
        uart_hold = 2;
        bus16.start = 1'b1;
        @(negedge clk);
        bus16.start = 1'b0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 5000; i++) begin
                @(negedge clk);
                if (bus16.EnTx && bus16.byte_cnt == 8'd5) begin
                    seen = 1'b1;
                    break;
                end
            end
            tally("reach_byte5", seen, 0, 1);
        end
        repeat (3) @(negedge clk);
        rst16 = 1'b1;
        uart_rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_mid_block", int'(obs16()), 0);
        @(negedge clk);
        rst16 = 1'b0;
        uart_rst = 1'b0;
        @(negedge clk);
        run_block16(100, 2, "blk_after_reset");

        // start held high: back-to-back blocks with one IDLE cycle between.
        uart_lat = 5;
        uart_hold = 2;
        clear_counts();
        bus16.start = 1'b1;
        wait_bd16("b2b_first");
        @(negedge clk);
        check("b2b_idle_gap", int'(bus16.busy), 0);
        @(negedge clk);
        check("b2b_reenter", int'(bus16.busy), 1);
        clear_counts();
        exp_idx = 0;
        bus16.start = 1'b0;
        repeat (40) @(negedge clk);
        bus16.start = 1'b1;  // mid-block pulse, must be ignored
        @(negedge clk);
        bus16.start = 1'b0;
        wait_bd16("b2b_second");
        check("b2b_ld", ld_n, 1);
        check("b2b_entx", tx_n, 16);
        repeat (5) @(negedge clk);
        check("no_queued_start", int'(bus16.busy), 0);
        check("b2b_bd_total", bd_n, 1);

        // tx_done never arrives on the single-byte instance.
        bus1.tx_done = 1'b0;
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        begin
            bit seen = 1'b0;
            int k = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus1.EnTx) begin
                    seen = 1'b1;
                    break;
                end
            end
            tally("wd_entx_seen", seen, 0, 1);
`ifdef TX_TIMEOUT_EN
            for (int i = 1; i <= 300; i++) begin
                @(negedge clk);
                if (bus1.block_done) begin
                    k = i;
                    break;
                end
            end
            tally("wd_latency", k >= 50 && k <= 52, k, 51);
            check("wd_err_set", int'(bus1.err), 1);
            repeat (3) @(negedge clk);
            check("wd_err_sticky", int'(bus1.err), 1);
            bus1.start = 1'b1;
            @(negedge clk);
            bus1.start = 1'b0;
            check("wd_err_cleared", int'(bus1.err), 0);
`else
            repeat (300) @(negedge clk);
            k = 300;
            check("nowd_busy", int'(bus1.busy), 1);
            check("nowd_err", int'(bus1.err), 0);
`endif
        end
        rst1 = 1'b1;
        @(posedge clk);
        #1;
        check("reset1_final", int'(obs1()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end
endmodule
